// File: rtl/mode_ctrl_pkg.sv
// Shared types and constants for the mode controller: display modes, edit fields
// and the BCD wrap limits used by the field incrementers.
package mode_ctrl_pkg;

  typedef enum logic [1:0] {
    CLOCK     = 2'd0,
    TIMER     = 2'd1,
    STOPWATCH = 2'd2,
    EDIT      = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    FLD_NONE    = 2'd0,
    FLD_HOURS   = 2'd1,
    FLD_MINUTES = 2'd2,
    FLD_SECONDS = 2'd3
  } field_t;

  localparam logic [7:0] HOURS_MAX  = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // Edit field rotation: hours -> minutes -> seconds -> hours.
  function automatic field_t next_field(input field_t f);
    case (f)
      FLD_HOURS:   return FLD_MINUTES;
      FLD_MINUTES: return FLD_SECONDS;
      default:     return FLD_HOURS;
    endcase
  endfunction

endpackage

// File: rtl/mode_ctrl_bcd_field_inc.sv
// Combinational two-digit BCD increment with a wrap limit; any out-of-range or
// non-BCD input wraps straight to 00.
module bcd_field_inc
  import mode_ctrl_pkg::*;
#(
  parameter logic [7:0] LIMIT = MINSEC_MAX
) (
  input  logic [7:0] i_val,
  output logic [7:0] o_val
);

  logic [3:0] w_hi;
  logic [3:0] w_lo;
  logic       w_wrap;

  assign w_hi   = i_val[7:4];
  assign w_lo   = i_val[3:0];
  assign w_wrap = (w_hi > 4'd9) || (w_lo > 4'd9) || (i_val >= LIMIT);

  always_comb begin
    if (w_wrap) begin
      o_val = 8'h00;
    end else if (w_lo == 4'd9) begin
      o_val = {w_hi + 4'd1, 4'd0};
    end else begin
      o_val = {w_hi, w_lo + 4'd1};
    end
  end

endmodule

// File: rtl/mode_ctrl.sv
// Watch-style mode controller: cycles CLOCK/TIMER/STOPWATCH/EDIT, edits a BCD
// HH:MM:SS value with blink and auto-repeat, and strobes load when leaving EDIT.
module mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int BLINK_DIV     = 12_500_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_sel,
  input  logic        btn_inc,
  input  logic        btn_inc_held,
  input  logic        lock,
  input  logic [23:0] time_in,
  output logic [1:0]  mode,
  output logic [1:0]  field,
  output logic        blink,
  output logic [23:0] edit_data,
  output logic        load
);

  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [REP_W-1:0]   DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]   PER_LAST   = REP_W'(REPEAT_PERIOD - 1);

  mode_t              r_state;
  mode_t              w_state_nxt;
  field_t             r_field;
  field_t             w_field_nxt;
  logic [23:0]        r_edit;
  logic [23:0]        w_edit_nxt;
  logic [23:0]        w_edit_inc;
  logic               r_load;
  logic               w_load_nxt;
  logic               r_blink;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               w_blink_rst;
  logic [REP_W-1:0]   r_rep_cnt;
  logic               r_rep_run;
  logic               w_rep_active;
  logic               w_rep_tick;
  logic               w_mode_ev;
  logic               w_in_edit;
  logic               w_sel_ev;
  logic               w_inc_ev;
  logic [7:0]         w_hr_inc;
  logic [7:0]         w_min_inc;
  logic [7:0]         w_sec_inc;

  // A locked mode press is treated as absent, so sel/inc still apply that cycle.
  assign w_mode_ev = btn_mode & ~lock;
  assign w_in_edit = (r_state == EDIT);
  assign w_sel_ev  = w_in_edit & ~w_mode_ev & btn_sel;
  assign w_inc_ev  = w_in_edit & ~w_mode_ev & ~btn_sel & (btn_inc | w_rep_tick);

  assign w_rep_active = w_in_edit & btn_inc_held;
  assign w_rep_tick   = w_rep_active &
                        (r_rep_run ? (r_rep_cnt == PER_LAST) : (r_rep_cnt == DELAY_LAST));

  bcd_field_inc #(.LIMIT(HOURS_MAX))  u_inc_hr  (.i_val(r_edit[23:16]), .o_val(w_hr_inc));
  bcd_field_inc #(.LIMIT(MINSEC_MAX)) u_inc_min (.i_val(r_edit[15:8]),  .o_val(w_min_inc));
  bcd_field_inc #(.LIMIT(MINSEC_MAX)) u_inc_sec (.i_val(r_edit[7:0]),   .o_val(w_sec_inc));

  always_comb begin
    w_edit_inc = r_edit;
    case (r_field)
      FLD_HOURS:   w_edit_inc[23:16] = w_hr_inc;
      FLD_MINUTES: w_edit_inc[15:8]  = w_min_inc;
      FLD_SECONDS: w_edit_inc[7:0]   = w_sec_inc;
      default:     w_edit_inc = r_edit;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= CLOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_ev) begin
      case (r_state)
        CLOCK:     w_state_nxt = TIMER;
        TIMER:     w_state_nxt = STOPWATCH;
        STOPWATCH: w_state_nxt = EDIT;
        default:   w_state_nxt = CLOCK;
      endcase
    end
  end

  always_comb begin
    w_field_nxt = r_field;
    w_edit_nxt  = r_edit;
    w_load_nxt  = 1'b0;
    w_blink_rst = 1'b0;
    if (w_mode_ev && (r_state == STOPWATCH)) begin
      w_field_nxt = FLD_HOURS;
      w_edit_nxt  = time_in;
      w_blink_rst = 1'b1;
    end else if (w_mode_ev && (r_state == EDIT)) begin
      w_field_nxt = FLD_NONE;
      w_load_nxt  = 1'b1;
    end else if (w_sel_ev) begin
      w_field_nxt = next_field(r_field);
      w_blink_rst = 1'b1;
    end else if (w_inc_ev) begin
      w_edit_nxt  = w_edit_inc;
      w_blink_rst = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_field <= FLD_NONE;
      r_edit  <= '0;
      r_load  <= 1'b0;
    end else begin
      r_field <= w_field_nxt;
      r_edit  <= w_edit_nxt;
      r_load  <= w_load_nxt;
    end
  end

  // Blink phase restarts on any visible edit so the changed digits show at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if ((w_state_nxt != EDIT) || w_blink_rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Repeat counter measures the initial delay first, then each repeat period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rep_cnt <= '0;
      r_rep_run <= 1'b0;
    end else if (!w_rep_active) begin
      r_rep_cnt <= '0;
      r_rep_run <= 1'b0;
    end else if (w_rep_tick) begin
      r_rep_cnt <= '0;
      r_rep_run <= 1'b1;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  assign mode      = r_state;
  assign field     = r_field;
  assign blink     = r_blink;
  assign edit_data = r_edit;
  assign load      = r_load;

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed scoreboard bench for mode_ctrl with short blink/repeat parameters.
module tb_mode_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        btn_mode = 1'b0;
  logic        btn_sel = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_inc_held = 1'b0;
  logic        lock = 1'b0;
  logic [23:0] time_in = '0;
  logic [1:0]  mode;
  logic [1:0]  field;
  logic        blink;
  logic [23:0] edit_data;
  logic        load;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [1:0]  mode;
    logic [1:0]  field;
    logic        chk_blink;
    logic        blink;
    logic [23:0] edit;
    logic        load;
  } exp_t;

  exp_t sb[$];

  mode_ctrl #(
    .BLINK_DIV(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_sel(btn_sel),
    .btn_inc(btn_inc),
    .btn_inc_held(btn_inc_held),
    .lock(lock),
    .time_in(time_in),
    .mode(mode),
    .field(field),
    .blink(blink),
    .edit_data(edit_data),
    .load(load)
  );

  always #5 clock = ~clock;

  task automatic push(input string tag, input logic [1:0] em, input logic [1:0] ef,
                      input logic bc, input logic eb, input logic [23:0] ed, input logic el);
    exp_t e;
    e.tag = tag; e.mode = em; e.field = ef; e.chk_blink = bc;
    e.blink = eb; e.edit = ed; e.load = el;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=0 entries expected=1");
      return;
    end
    e = sb.pop_front();
    assert (mode === e.mode) else begin
      failures++;
      $error("FAIL %s.mode observed=%0h expected=%0h", e.tag, mode, e.mode);
    end
    checks++;
    assert (field === e.field) else begin
      failures++;
      $error("FAIL %s.field observed=%0h expected=%0h", e.tag, field, e.field);
    end
    checks++;
    assert (edit_data === e.edit) else begin
      failures++;
      $error("FAIL %s.edit_data observed=%06h expected=%06h", e.tag, edit_data, e.edit);
    end
    checks++;
    assert (load === e.load) else begin
      failures++;
      $error("FAIL %s.load observed=%0b expected=%0b", e.tag, load, e.load);
    end
    if (e.chk_blink) begin
      checks++;
      assert (blink === e.blink) else begin
        failures++;
        $error("FAIL %s.blink observed=%0b expected=%0b", e.tag, blink, e.blink);
      end
    end
  endtask

  // One clock cycle: pulses driven at negedge, outputs compared 1 time unit after posedge.
  task automatic go(input logic m, input logic s, input logic i, input string tag,
                    input logic [1:0] em, input logic [1:0] ef, input logic bc,
                    input logic eb, input logic [23:0] ed, input logic el);
    push(tag, em, ef, bc, eb, ed, el);
    @(negedge clock);
    btn_mode = m; btn_sel = s; btn_inc = i;
    @(posedge clock);
    #1;
    btn_mode = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
    check_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] exp_ed;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    push("reset_async", 2'd0, 2'd0, 1'b1, 1'b0, 24'h0, 1'b0);
    check_pop();
    @(negedge clock);
    reset = 1'b1;

    // Mode sequence with a single load on the fourth press
    time_in = 24'h123456;
    go(1, 0, 0, "seq_timer", 2'd1, 2'd0, 1, 0, 24'h000000, 0);
    go(1, 0, 0, "seq_stopwatch", 2'd2, 2'd0, 1, 0, 24'h000000, 0);
    go(1, 0, 0, "seq_edit", 2'd3, 2'd1, 1, 0, 24'h123456, 0);
    go(1, 0, 0, "seq_clock_load", 2'd0, 2'd0, 1, 0, 24'h123456, 1);
    go(0, 0, 0, "seq_load_drop", 2'd0, 2'd0, 1, 0, 24'h123456, 0);

    // Lock inhibits mode; sel/inc ignored outside EDIT
    lock = 1'b1;
    go(1, 0, 0, "lock_1", 2'd0, 2'd0, 1, 0, 24'h123456, 0);
    go(1, 0, 0, "lock_2", 2'd0, 2'd0, 1, 0, 24'h123456, 0);
    go(1, 0, 0, "lock_3", 2'd0, 2'd0, 1, 0, 24'h123456, 0);
    lock = 1'b0;
    go(0, 1, 1, "ignore_sel_inc", 2'd0, 2'd0, 1, 0, 24'h123456, 0);

    // Wrap every field from 23:59:59
    time_in = 24'h235959;
    go(1, 0, 0, "wrap_m1", 2'd1, 2'd0, 1, 0, 24'h123456, 0);
    go(1, 0, 0, "wrap_m2", 2'd2, 2'd0, 1, 0, 24'h123456, 0);
    go(1, 0, 0, "wrap_enter", 2'd3, 2'd1, 1, 0, 24'h235959, 0);
    go(0, 0, 1, "wrap_hr", 2'd3, 2'd1, 1, 0, 24'h005959, 0);
    go(0, 1, 0, "wrap_sel_min", 2'd3, 2'd2, 1, 0, 24'h005959, 0);
    go(0, 0, 1, "wrap_min", 2'd3, 2'd2, 1, 0, 24'h000059, 0);
    go(0, 1, 0, "wrap_sel_sec", 2'd3, 2'd3, 1, 0, 24'h000059, 0);
    go(0, 0, 1, "wrap_sec", 2'd3, 2'd3, 1, 0, 24'h000000, 0);
    go(1, 0, 0, "wrap_load", 2'd0, 2'd0, 1, 0, 24'h000000, 1);
    go(0, 0, 0, "wrap_load_drop", 2'd0, 2'd0, 1, 0, 24'h000000, 0);

    // Blink cadence, then auto-repeat on minutes
    time_in = 24'h105730;
    go(1, 0, 0, "rep_m1", 2'd1, 2'd0, 1, 0, 24'h000000, 0);
    go(1, 0, 0, "rep_m2", 2'd2, 2'd0, 1, 0, 24'h000000, 0);
    go(1, 0, 0, "rep_enter", 2'd3, 2'd1, 1, 0, 24'h105730, 0);
    for (int k = 1; k <= 8; k++) begin
      go(0, 0, 0, $sformatf("blink_%0d", k), 2'd3, 2'd1, 1, (k >= 4 && k < 8), 24'h105730, 0);
    end
    go(0, 1, 0, "rep_sel", 2'd3, 2'd2, 1, 0, 24'h105730, 0);
    btn_inc_held = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k < 8)       exp_ed = 24'h105730;
      else if (k < 11) exp_ed = 24'h105830;
      else if (k < 14) exp_ed = 24'h105930;
      else             exp_ed = 24'h100030;
      go(0, 0, 0, $sformatf("repeat_%0d", k), 2'd3, 2'd2, 0, 0, exp_ed, 0);
    end
    btn_inc_held = 1'b0;
    go(0, 0, 0, "repeat_release", 2'd3, 2'd2, 0, 0, 24'h100030, 0);
    go(0, 0, 0, "repeat_stopped", 2'd3, 2'd2, 0, 0, 24'h100030, 0);

    // Mode wins over a coincident increment
    go(1, 0, 1, "prio_load", 2'd0, 2'd0, 1, 0, 24'h100030, 1);
    go(0, 0, 0, "prio_drop", 2'd0, 2'd0, 1, 0, 24'h100030, 0);

    // Invalid hours captured as-is, then reset in EDIT while blinking
    time_in = 24'h3A0203;
    go(1, 0, 0, "rst_m1", 2'd1, 2'd0, 1, 0, 24'h100030, 0);
    go(1, 0, 0, "rst_m2", 2'd2, 2'd0, 1, 0, 24'h100030, 0);
    go(1, 0, 0, "rst_enter", 2'd3, 2'd1, 1, 0, 24'h3A0203, 0);
    go(0, 0, 1, "invalid_hr_inc", 2'd3, 2'd1, 1, 0, 24'h000203, 0);
    go(0, 1, 0, "rst_sel2", 2'd3, 2'd2, 1, 0, 24'h000203, 0);
    go(0, 1, 0, "rst_sel3", 2'd3, 2'd3, 1, 0, 24'h000203, 0);
    for (int k = 1; k <= 4; k++) begin
      go(0, 0, 0, $sformatf("rst_blink_%0d", k), 2'd3, 2'd3, 1, (k == 4), 24'h000203, 0);
    end
    #2 reset = 1'b0;
    #1;
    push("rst_immediate", 2'd0, 2'd0, 1, 0, 24'h0, 0);
    check_pop();
    go(1, 0, 0, "rst_hold_1", 2'd0, 2'd0, 1, 0, 24'h0, 0);
    go(0, 0, 0, "rst_hold_2", 2'd0, 2'd0, 1, 0, 24'h0, 0);

    // First edge after release acts on a mode press
    push("rst_release_edge", 2'd1, 2'd0, 1, 0, 24'h0, 0);
    @(negedge clock);
    reset = 1'b1;
    btn_mode = 1'b1;
    @(posedge clock);
    #1;
    btn_mode = 1'b0;
    check_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
